// File: rtl/id_exe_hazard_ctrl_pkg.sv
// Shared FSM state encoding and pipeline control bundle for the ID/EXE hazard controller.
package id_exe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HzRun     = 2'd0,
    HzFlush   = 2'd1,
    HzMemWait = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic id_exe_hold;
    logic id_exe_bubble;
  } hz_ctrl_t;

  localparam hz_ctrl_t CtrlNop = '{
    pc_hold: 1'b0, if_id_hold: 1'b0, if_id_flush: 1'b0, id_exe_hold: 1'b0, id_exe_bubble: 1'b0
  };

  localparam hz_ctrl_t CtrlFlush = '{
    pc_hold: 1'b0, if_id_hold: 1'b0, if_id_flush: 1'b1, id_exe_hold: 1'b0, id_exe_bubble: 1'b1
  };

  localparam hz_ctrl_t CtrlMemHold = '{
    pc_hold: 1'b1, if_id_hold: 1'b1, if_id_flush: 1'b0, id_exe_hold: 1'b1, id_exe_bubble: 1'b0
  };

  localparam hz_ctrl_t CtrlLoadUse = '{
    pc_hold: 1'b1, if_id_hold: 1'b1, if_id_flush: 1'b0, id_exe_hold: 1'b0, id_exe_bubble: 1'b1
  };

  function automatic logic ctrl_stalls(hz_ctrl_t c);
    return c.pc_hold | c.id_exe_hold | c.id_exe_bubble;
  endfunction

endpackage

// File: rtl/id_exe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {Width{1'b1}})) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/id_exe_hazard_ctrl.sv
// ID/EXE hazard sequencer: load-use stalls, redirect flushes and data-memory freezes,
// with a saturating stall-cycle counter.
module id_exe_hazard_ctrl
  import id_exe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned ASIZE        = 5,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] id_rs1,
  input  logic [ASIZE-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic             ex_wen,
  input  logic [ASIZE-1:0] ex_waddr,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_exe_hold,
  output logic             id_exe_bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned FcW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FcW-1:0] FlushReload = FcW'(FLUSH_CYCLES - 1);

  hz_state_e      state_q, state_d;
  hz_state_e      ret_q, ret_d;
  hz_state_e      eff_state;
  logic [FcW-1:0] flush_cnt_q, flush_cnt_d;
  hz_ctrl_t       ctrl;
  logic           load_use;

  assign load_use = ex_mem_read && ex_wen && (ex_waddr != '0) &&
                    ((ex_waddr == id_rs1) || (id_uses_rs2 && (ex_waddr == id_rs2)));

  // Leaving MEM_WAIT behaves exactly like the state that was frozen.
  assign eff_state = (state_q == HzMemWait) ? ret_q : state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HzRun;
      ret_q       <= HzRun;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    flush_cnt_d = flush_cnt_q;
    ctrl        = CtrlNop;

    if (rst) begin
      ctrl = CtrlFlush;
    end else if (mem_busy) begin
      ctrl    = CtrlMemHold;
      state_d = HzMemWait;
      ret_d   = eff_state;
    end else if (ex_redirect) begin
      ctrl = CtrlFlush;
      if (FLUSH_CYCLES > 1) begin
        state_d     = HzFlush;
        flush_cnt_d = FlushReload;
      end else begin
        state_d = HzRun;
      end
    end else if (eff_state == HzFlush) begin
      ctrl = CtrlFlush;
      if (flush_cnt_q <= FcW'(1)) begin
        state_d     = HzRun;
        flush_cnt_d = '0;
      end else begin
        state_d     = HzFlush;
        flush_cnt_d = flush_cnt_q - FcW'(1);
      end
    end else begin
      // Bubble in ID/EXE removes the hazard next cycle, so the stall is single-cycle.
      if (load_use) begin
        ctrl = CtrlLoadUse;
      end
      state_d = HzRun;
    end
  end

  assign pc_hold       = ctrl.pc_hold;
  assign if_id_hold    = ctrl.if_id_hold;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_exe_hold   = ctrl.id_exe_hold;
  assign id_exe_bubble = ctrl.id_exe_bubble;

  sat_counter #(
    .Width(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (ctrl_stalls(ctrl)),
    .count(stall_cnt)
  );

endmodule
